// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (IEEE 1149.1 values),
// instruction opcodes shared with the IR block, and TDO source select.
// Optional feature macro used by the TAP files: TAP_IDCODE_EN.
package jtag_pkg;

  localparam int unsigned IR_DATA_WIDTH = 4;
  localparam int unsigned STATE_WIDTH   = 4;

  // TAP controller states, encoded with the standard 1149.1 values
  typedef enum logic [STATE_WIDTH-1:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  // Opcodes shared with the instruction register block
  localparam logic [IR_DATA_WIDTH-1:0] BYPASS_OP = 4'hF;
  localparam logic [IR_DATA_WIDTH-1:0] IDCODE_OP = 4'h1;
  localparam logic [IR_DATA_WIDTH-1:0] USER_OP   = 4'h8;

  // Source steered onto TDO
  typedef enum logic [1:0] {
    TDO_SRC_IR     = 2'd0,
    TDO_SRC_BYPASS = 2'd1,
    TDO_SRC_IDCODE = 2'd2,
    TDO_SRC_USER   = 2'd3
  } tdo_src_e;

endpackage

// File: rtl/tap_ir_decode.sv
// Combinational decode of the latched instruction into a one-hot DR select.
// TAP_IDCODE_EN defined: IDCODE_OP selects the IDCODE DR.
// TAP_IDCODE_EN undefined: IDCODE_OP falls through to bypass, sel_idcode is 0.
module tap_ir_decode
  import jtag_pkg::*;
(
  input  logic [IR_DATA_WIDTH-1:0] latch_ir,
  output logic                     sel_bypass,
  output logic                     sel_idcode,
  output logic                     sel_user
);

  // Priority-free decode; unknown opcodes land on bypass so one select is always high
  always_comb begin
    sel_bypass = 1'b0;
    sel_idcode = 1'b0;
    sel_user   = 1'b0;
    if (latch_ir == USER_OP) begin
      sel_user = 1'b1;
    end
`ifdef TAP_IDCODE_EN
    else if (latch_ir == IDCODE_OP) begin
      sel_idcode = 1'b1;
    end
`endif
    else begin
      sel_bypass = 1'b1;
    end
  end

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with strobe generation, DR select decode
// and negedge-timed TDO steering.
// Optional feature macro: TAP_IDCODE_EN (routes IDCODE_TDO when defined).
module tap_controller
  import jtag_pkg::*;
(
  input  logic                     TCK,
  input  logic                     TRST,
  input  logic                     TMS,
  input  logic [IR_DATA_WIDTH-1:0] LATCH_IR,
  input  logic                     I_TDO,
  input  logic                     BYPASS_TDO,
  input  logic                     IDCODE_TDO,
  input  logic                     USER_TDO,
  output logic                     TLR,
  output logic                     CAPTURE_IR,
  output logic                     SHIFT_IR,
  output logic                     UPDATE_IR,
  output logic                     CAPTURE_DR,
  output logic                     SHIFT_DR,
  output logic                     UPDATE_DR,
  output logic                     SEL_BYPASS,
  output logic                     SEL_IDCODE,
  output logic                     SEL_USER,
  output logic                     TDO,
  output logic                     TDO_EN,
  output logic [STATE_WIDTH-1:0]   STATE
);

  tap_state_e state_q;
  tap_state_e state_d;
  logic       tdo_en_d;
  logic       tdo_en_q;
  tdo_src_e   tdo_src_d;
  tdo_src_e   tdo_src_q;
  tdo_src_e   dr_src;
  logic       dr_sel_any;

  tap_ir_decode u_ir_decode (
    .latch_ir   (LATCH_IR),
    .sel_bypass (SEL_BYPASS),
    .sel_idcode (SEL_IDCODE),
    .sel_user   (SEL_USER)
  );

  // State register; TRST forces Test-Logic-Reset asynchronously
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic following the 1149.1 TMS transition graph
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:    state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:    state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // Serial source of the currently selected data register
  always_comb begin
    dr_sel_any = SEL_BYPASS | SEL_IDCODE | SEL_USER;
    dr_src     = TDO_SRC_BYPASS;
    if (SEL_USER) begin
      dr_src = TDO_SRC_USER;
    end else if (SEL_IDCODE) begin
      dr_src = TDO_SRC_IDCODE;
    end
  end

  // Output decode: strobes for the current state plus next TDO enable/source
  always_comb begin
    TLR        = 1'b0;
    CAPTURE_IR = 1'b0;
    SHIFT_IR   = 1'b0;
    UPDATE_IR  = 1'b0;
    CAPTURE_DR = 1'b0;
    SHIFT_DR   = 1'b0;
    UPDATE_DR  = 1'b0;
    tdo_en_d   = 1'b0;
    tdo_src_d  = dr_src;
    case (state_q)
      ST_TLR:    TLR = 1'b1;
      ST_CAP_IR: CAPTURE_IR = 1'b1;
      ST_SH_IR: begin
        SHIFT_IR  = 1'b1;
        tdo_en_d  = 1'b1;
        tdo_src_d = TDO_SRC_IR;
      end
      ST_UPD_IR: UPDATE_IR = 1'b1;
      ST_CAP_DR: CAPTURE_DR = dr_sel_any;
      ST_SH_DR: begin
        SHIFT_DR = dr_sel_any;
        tdo_en_d = 1'b1;
      end
      ST_UPD_DR: UPDATE_DR = dr_sel_any;
      default: ;
    endcase
  end

  // TDO enable and mux select change on the falling edge, half a cycle after the state
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_en_q  <= 1'b0;
      tdo_src_q <= TDO_SRC_IR;
    end else begin
      tdo_en_q  <= tdo_en_d;
      tdo_src_q <= tdo_src_d;
    end
  end

  // TDO mux; sources are already negedge-registered by their owners
  always_comb begin
    TDO = I_TDO;
    case (tdo_src_q)
      TDO_SRC_BYPASS: TDO = BYPASS_TDO;
      TDO_SRC_USER:   TDO = USER_TDO;
`ifdef TAP_IDCODE_EN
      TDO_SRC_IDCODE: TDO = IDCODE_TDO;
`endif
      default:        TDO = I_TDO;
    endcase
  end

`ifndef TAP_IDCODE_EN
  // IDCODE DR is absent in this build; its serial output is intentionally dropped
  logic unused_idcode_tdo;
  assign unused_idcode_tdo = IDCODE_TDO;
`endif

  assign TDO_EN = tdo_en_q;
  assign STATE  = state_q;

  // Exactly one data register is selected at every clock
  always @(posedge TCK) begin
    assert ($onehot({SEL_BYPASS, SEL_IDCODE, SEL_USER}))
      else $error("DR select not one-hot");
  end

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1 TAP state machine and TDO steering for the JTAG block. It is clocked by TCK and steered by TMS. It generates the capture/shift/update/reset strobes consumed by the 4-bit instruction register and the data registers. It decodes the latched instruction into data-register selects and multiplexes the serial outputs onto TDO with a negedge-timed enable.

## Interface
- IR_DATA_WIDTH, 4, instruction width; must match the IR block.
- BYPASS_OP, 4'hF, opcode selecting the bypass DR.
- IDCODE_OP, 4'h1, opcode selecting the IDCODE DR.
- USER_OP, 4'h8, opcode selecting the user DR.
- TCK  in  1  test clock; all state changes on posedge.
- TRST  in  1  reset, asynchronous, active-low.
- TMS  in  1  mode select, sampled on posedge TCK.
- LATCH_IR  in  IR_DATA_WIDTH  current instruction from the IR block.
- I_TDO, BYPASS_TDO, IDCODE_TDO, USER_TDO  in  1 each  serial outputs, each already negedge-registered by its owner.
- TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR  out  1 each  IR strobes.
- CAPTURE_DR, SHIFT_DR, UPDATE_DR  out  1 each  DR strobes, qualified by the DR selects.
- SEL_BYPASS, SEL_IDCODE, SEL_USER  out  1 each  one-hot DR select.
- TDO  out  1  serial data out.
- TDO_EN  out  1  output enable for the TDO pad.
- STATE  out  4  current state, for debug.

## Operation
- State encoding uses the 1149.1 values:
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5.
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D.
- Transitions, written as TMS=0 target / TMS=1 target:
  - TLR: RTI / TLR. RTI: RTI / SEL_DR. SEL_DR: CAP_DR / SEL_IR. SEL_IR: CAP_IR / TLR.
  - CAP_x: SH_x / EX1_x. SH_x: SH_x / EX1_x. EX1_x: PAUSE_x / UPD_x.
  - PAUSE_x: PAUSE_x / EX2_x. EX2_x: SH_x / UPD_x. UPD_x: RTI / SEL_DR.
- Any state reaches TLR after 5 consecutive TMS=1 edges.
- Strobes are a combinational decode of the state register:
  - TLR=1 in TLR. CAPTURE_IR=1 in CAP_IR. SHIFT_IR=1 in SH_IR. UPDATE_IR=1 in UPD_IR.
  - The DR strobes assert in the matching DR states.
- Instruction decode of LATCH_IR:
  - BYPASS_OP asserts SEL_BYPASS. USER_OP asserts SEL_USER. IDCODE_OP asserts SEL_IDCODE (see Configuration).
  - Any other code asserts SEL_BYPASS.
  - Exactly one select is high at all times.
- TDO mux: in SH_IR, TDO follows I_TDO. Otherwise TDO follows the serial output of the selected DR.
- The mux select is registered on negedge TCK.

## Timing
- Reset: TRST low forces STATE=TLR immediately, asynchronously.
  - Resulting outputs: TLR=1, all other strobes 0, TDO_EN=0, TDO select = I_TDO path.
  - Decode selects follow LATCH_IR combinationally; LATCH_IR is BYPASS at reset, so SEL_BYPASS=1.
- TRST low mid-shift aborts the shift. The FSM leaves TLR only on the first posedge after TRST rises, and only with TMS=0.
- A strobe is high for exactly the TCK period in which its state is current.
  - The IR samples CAPTURE_IR/SHIFT_IR on the posedge that leaves that state.
  - The IR samples UPDATE_IR on the negedge within UPD_IR.
- TDO_EN is registered on negedge TCK. It is 1 after the falling edge inside SH_IR or SH_DR, and 0 after the falling edge in any other state.
- TDO is valid from the falling edge and is held until the next falling edge.
- STATE changes only on posedge TCK, with one-edge latency from TMS.

## Configuration
- TAP_IDCODE_EN:
  - Defined: IDCODE_OP asserts SEL_IDCODE, and the TDO mux routes IDCODE_TDO.
  - Undefined: SEL_IDCODE is tied 0, IDCODE_OP decodes to SEL_BYPASS, and IDCODE_TDO is unused.

## Structure
- Shared package jtag_pkg holds the 4-bit state typedef and all 16 state constants.
- It also holds the opcode constants BYPASS_OP, IDCODE_OP and USER_OP, which are shared with the IR block.
- One sub-module, tap_ir_decode, is natural: combinational LATCH_IR to one-hot select, with the TAP_IDCODE_EN handling inside it.

## Test plan
- TRST pulse low from SH_DR -> STATE=F, TLR=1, TDO_EN=0 immediately; stays in TLR while TMS=1.
- From each of the 16 states, 5 TMS=1 edges -> STATE=F.
- Shift IR:
  - Stimulus: TMS 0,1,1,0,0 then 3×0 and 1,1,0 with TDI=1,0,0,0.
  - Required: CAPTURE_IR high one cycle in state E; SHIFT_IR high 4 cycles; UPDATE_IR high in state D.
  - Required: TDO_EN high only across the shift, and TDO shows 1,0,1,0 (capture value 0101 LSB first).
- LATCH_IR=4'h8, SH_DR -> SEL_USER=1 and TDO tracks USER_TDO; LATCH_IR=4'h3 -> SEL_BYPASS=1.
- LATCH_IR=4'h1: with TAP_IDCODE_EN -> SEL_IDCODE=1 and TDO=IDCODE_TDO; without -> SEL_BYPASS=1 and TDO=BYPASS_TDO.
- PAUSE_DR held 10 cycles, then EX2_DR→SH_DR -> SHIFT_DR resumes; TDO_EN=0 during pause, 1 during shift.
